// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide, one bit per cycle.
// Ports: clk, reset (async, active-low), start, flush, Funct3,
//   SrcA, SrcB -> busy, done, Result.
// Macro MULDIV_FAST_SPECIAL_EN: div-by-zero/overflow skip to DONE.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  localparam logic [XLEN-1:0] MINV =
    {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0] LAST = 6'(XLEN-1);

  state_t state, nstate;

  logic [2:0]        f3;
  logic              na, nb;
  logic              divz, ovf;
  logic [5:0]        cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] sh;
  logic [XLEN-1:0]   opb;
  logic              busy_nx, done_nx;

  logic              accept;
  logic              sa_in, sb_in;
  logic              na_in, nb_in;
  logic              divz_in, ovf_in;
  logic              special_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   special_res;

  assign accept = (state == IDLE) && start && !flush;

  always_comb begin
    sa_in = 1'b0;
    sb_in = 1'b0;
    unique case (Funct3)
      3'b001, 3'b100, 3'b110: begin
        sa_in = 1'b1;
        sb_in = 1'b1;
      end
      3'b010: sa_in = 1'b1;
      default: ;
    endcase
  end

  assign na_in = sa_in & SrcA[XLEN-1];
  assign nb_in = sb_in & SrcB[XLEN-1];
  assign mag_a = na_in ? -SrcA : SrcA;
  assign mag_b = nb_in ? -SrcB : SrcB;

  assign divz_in = Funct3[2] && (SrcB == '0);
  assign ovf_in  = Funct3[2] && !Funct3[0] &&
                   (SrcA == MINV) && (&SrcB);

  always_comb begin
    special_res = '0;
    if (divz_in)
      special_res = Funct3[1] ? SrcA : '1;
    else if (ovf_in)
      special_res = Funct3[1] ? '0 : MINV;
  end

`ifdef MULDIV_FAST_SPECIAL_EN
  assign special_in = divz_in | ovf_in;
`else
  assign special_in = 1'b0;
`endif

  // Restoring divide step: remainder pulls in
  // the next dividend bit from the top of sh.
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] sub;

  assign rem_sh = {acc[2*XLEN-1:XLEN], sh[XLEN-1]};
  assign ge     = rem_sh >= {1'b0, opb};
  assign sub    = rem_sh[XLEN-1:0] - opb;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  assign prod = (na ^ nb) ? -acc : acc;
  assign quo  = (na ^ nb) ? -acc[XLEN-1:0]
                          : acc[XLEN-1:0];
  assign rem  = na ? -acc[2*XLEN-1:XLEN]
                   : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    unique case (1'b1)
      divz: fix_res = f3[1] ? rem : '1;
      ovf:  fix_res = f3[1] ? '0 : MINV;
      default: begin
        unique case (f3)
          3'b000: fix_res = prod[XLEN-1:0];
          3'b001, 3'b010, 3'b011:
            fix_res = prod[2*XLEN-1:XLEN];
          3'b100, 3'b101: fix_res = quo;
          default: fix_res = rem;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:
        if (accept)
          nstate = special_in ? DONE : CALC;
      CALC:
        if (flush)             nstate = IDLE;
        else if (cnt == LAST)  nstate = FIX;
      FIX:  nstate = flush ? IDLE : DONE;
      DONE: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy_nx = (nstate == CALC) || (nstate == FIX);
    done_nx = (nstate == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f3     <= '0;
      na     <= 1'b0;
      nb     <= 1'b0;
      divz   <= 1'b0;
      ovf    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      sh     <= '0;
      opb    <= '0;
      Result <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (accept) begin
            f3   <= Funct3;
            na   <= na_in;
            nb   <= nb_in;
            divz <= divz_in;
            ovf  <= ovf_in;
            cnt  <= '0;
            acc  <= '0;
            sh   <= {{XLEN{1'b0}}, mag_a};
            opb  <= mag_b;
            if (special_in)
              Result <= special_res;
          end
        CALC:
          if (!flush) begin
            cnt <= cnt + 6'd1;
            sh  <= sh << 1;
            if (f3[2]) begin
              acc <= ge ?
                {sub, acc[XLEN-2:0], 1'b1} :
                {rem_sh[XLEN-1:0],
                 acc[XLEN-2:0], 1'b0};
            end else begin
              if (opb[0]) acc <= acc + sh;
              opb <= opb >> 1;
            end
          end
        FIX:
          if (!flush) Result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide unit sharing the execute stage with the main ALU. Decodes Funct3 of an M-extension instruction (Funct7 = 0000001), runs a radix-2 shift-add multiply or restoring divide one bit per cycle, and returns a 32-bit result through a start/busy/done handshake. The pipeline stall logic holds the execute stage while `busy` is high and writes `Result` back on `done`.

## Interface
- `XLEN`, 32: operand/result width; iteration count equals `XLEN`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `flush`  in  1  synchronous abort of the operation in flight.
- `Funct3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcA`  in  XLEN  rs1 (multiplicand/dividend).
- `SrcB`  in  XLEN  rs2 (multiplier/divisor).
- `busy`  out  1  high in CALC and FIX.
- `done`  out  1  single-cycle pulse; `Result` valid.
- `Result`  out  XLEN  held from `done` until the next accepted `start`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE + `start`: latch `Funct3`, record operand signs (signed for MULH/DIV/REM on both operands, `SrcA` only for MULHSU), store magnitudes, clear the 2·XLEN accumulator and the 6-bit counter, then go to CALC.
- CALC: one iteration per cycle. Multiply: add the shifted multiplicand when the multiplier LSB is 1, then shift. Divide: shift the remainder left, trial-subtract the divisor, set the quotient bit when the difference is ≥ 0. After counter = XLEN−1 go to FIX.
- FIX: negate the product when the signs differ. Negate the quotient when the signs differ. Give the remainder the dividend's sign. Select the low word (MUL) or the high word (MULH*), or the quotient/remainder. Register `Result`, then go to DONE.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- Special results are mandatory in every configuration:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `SrcA`.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- `start` outside IDLE is ignored. It is not queued.
- `flush` in CALC or FIX: go to IDLE next cycle with no `done`; `Result` is unchanged. `flush` in IDLE or DONE has no effect. `flush` and `start` together in IDLE: `flush` wins, nothing is accepted.
- Reset (asynchronous, any state): state IDLE, `busy` 0, `done` 0, `Result` 0, counter 0, accumulator 0.

## Timing
- Normal latency: `start` accepted at edge E0; CALC spans E0..E(XLEN); FIX spans E(XLEN)..E(XLEN+1); `done` is high for the cycle after E(XLEN+1). That is XLEN+2 = 34 cycles from acceptance to `done`.
- `busy` is registered: it rises the cycle after acceptance and falls in the same cycle `done` rises.
- The earliest next acceptance is the cycle after `done`, that is, back-to-back operations every XLEN+3 cycles.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- `MULDIV_FAST_SPECIAL_EN` defined: divide-by-zero and signed-overflow cases detected in IDLE go straight to DONE. `busy` stays 0, and `done` with the special value arrives 1 cycle after acceptance.
- Not defined: these cases take the full XLEN+2 path, and FIX forces the special values. Results are identical in both configurations; only latency differs.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) -> `Result` 0xFFFFFFEB; `done` exactly 34 cycles after acceptance; `busy` high for 33 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF; MULH 0x80000000 × 0x80000000 -> 0x40000000.
- DIV −7 / 2 -> 0xFFFFFFFD; REM −7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0. Check `done` at 1 cycle with the macro and 34 cycles without.
- `flush` at cycle 10 of CALC -> IDLE next cycle, no `done`, `Result` keeps its previous value. A second `start` during CALC is ignored, and the first result is returned unchanged.
- Assert `reset` low mid-CALC -> all outputs 0 immediately. After release, a new MUL 3 × 4 -> 12 with nominal latency.
